// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch stages: seven-segment glyphs (active-low
// {a,b,c,d,e,f,g}) and the width helper used to size counters.
package stopwatch_pkg;

   localparam logic [6:0] SEG_0    = 7'b0000001;
   localparam logic [6:0] SEG_1    = 7'b1001111;
   localparam logic [6:0] SEG_2    = 7'b0010010;
   localparam logic [6:0] SEG_3    = 7'b0000110;
   localparam logic [6:0] SEG_4    = 7'b1001100;
   localparam logic [6:0] SEG_5    = 7'b0100100;
   localparam logic [6:0] SEG_6    = 7'b0100000;
   localparam logic [6:0] SEG_7    = 7'b0001111;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0000100;
   localparam logic [6:0] SEG_DASH = 7'b1111110;

   // Ceiling log2, never below one bit so a degenerate counter still has a port.
   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern; non-BCD nibbles show a dash.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Glyph lookup
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_stage.sv
// One modulo-N stopwatch digit group: prescaler, up/down binary count with a
// lock-stepped BCD mirror, seven-segment decode and a cascadable carry.
module stopwatch_stage
   import stopwatch_pkg::*;
#(
   parameter int  MODULO   = 60,
   parameter int  DIGITS   = 2,
   parameter int  PRESCALE = 250000,
   localparam int CW       = clog2_min1(MODULO)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  dir,
   input  logic                  load,
   input  logic [CW-1:0]         load_val,
   output logic [CW-1:0]         count,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  tc
);

   localparam int BW = 4 * DIGITS;
   localparam int PW = clog2_min1(PRESCALE);
   localparam logic [CW-1:0] MAX_CNT  = CW'(MODULO - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   // Shift-and-add-3 conversion; only used for load values and the wrap constant.
   function automatic logic [BW-1:0] bin2bcd(input logic [CW-1:0] bin);
      logic [BW-1:0] acc;
      acc = '0;
      for (int i = CW - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
               acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
         end
         acc = {acc[BW-2:0], bin[i]};
      end
      return acc;
   endfunction

   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      logic          carry;
      r     = b;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (r[4*d +: 4] == 4'd9) begin
               r[4*d +: 4] = 4'd0;
            end else begin
               r[4*d +: 4] = r[4*d +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      logic          borrow;
      r      = b;
      borrow = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (borrow) begin
            if (r[4*d +: 4] == 4'd0) begin
               r[4*d +: 4] = 4'd9;
            end else begin
               r[4*d +: 4] = r[4*d +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [BW-1:0] BCD_MAX = bin2bcd(MAX_CNT);

   logic [PW-1:0] r_pre;
   logic [CW-1:0] r_count;
   logic [BW-1:0] r_bcd;
   logic          w_tick;
   logic          w_at_end;
   logic [CW-1:0] w_load_sat;
   logic [CW-1:0] w_cnt_step;
   logic [BW-1:0] w_bcd_step;
   logic [7*DIGITS-1:0] w_seg;

   assign w_tick     = enable & (r_pre == PRE_LAST);
   assign w_at_end   = dir ? (r_count == MAX_CNT) : (r_count == {CW{1'b0}});
   assign w_load_sat = ({1'b0, load_val} >= (CW + 1)'(MODULO)) ? MAX_CNT : load_val;

   // Next count/bcd for a tick in the current direction, including the wrap values
   always_comb begin
      w_cnt_step = r_count;
      w_bcd_step = r_bcd;
      if (dir) begin
         if (w_at_end) begin
            w_cnt_step = {CW{1'b0}};
            w_bcd_step = {BW{1'b0}};
         end else begin
            w_cnt_step = r_count + CW'(1);
            w_bcd_step = bcd_inc(r_bcd);
         end
      end else begin
         if (w_at_end) begin
            w_cnt_step = MAX_CNT;
            w_bcd_step = BCD_MAX;
         end else begin
            w_cnt_step = r_count - CW'(1);
            w_bcd_step = bcd_dec(r_bcd);
         end
      end
   end

   // State registers: clear beats load beats tick; prescaler holds while paused
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre   <= '0;
         r_count <= '0;
         r_bcd   <= '0;
      end else if (clear) begin
         r_pre   <= '0;
         r_count <= '0;
         r_bcd   <= '0;
      end else if (load) begin
         r_pre   <= '0;
         r_count <= w_load_sat;
         r_bcd   <= bin2bcd(w_load_sat);
      end else if (w_tick) begin
         r_pre   <= '0;
         r_count <= w_cnt_step;
         r_bcd   <= w_bcd_step;
      end else if (enable) begin
         r_pre   <= r_pre + PW'(1);
      end else begin
         r_pre   <= r_pre;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      seg7_decode u_dec (
         .i_bcd (r_bcd[4*g +: 4]),
         .o_seg (w_seg[7*g +: 7])
      );
   end

   assign count = r_count;
   assign bcd   = r_bcd;
   assign seg   = w_seg;
   // Carry is suppressed while clear/load override the step or reset is held
   assign tc    = w_tick & w_at_end & ~clear & ~load & ~reset;

endmodule

// File: tb/tb_stopwatch_stage.sv
// Directed bench for stopwatch_stage: vector table plus hand-written sequences
// for carry pulses, async reset, pause/resume and a seconds->minutes cascade.
module tb_stopwatch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic        dir = 1'b0;
   logic        load = 1'b0;
   logic [5:0]  load_val = 6'd0;
   logic [5:0]  count;
   logic [7:0]  bcd;
   logic [13:0] seg;
   logic        tc;

   logic        sec_en = 1'b0;
   logic [5:0]  sec_count, min_count;
   logic [7:0]  sec_bcd, min_bcd;
   logic [13:0] sec_seg, min_seg;
   logic        sec_tc, min_tc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stopwatch_stage #(.MODULO(60), .DIGITS(2), .PRESCALE(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear), .dir(dir),
      .load(load), .load_val(load_val), .count(count), .bcd(bcd), .seg(seg), .tc(tc)
   );

   stopwatch_stage #(.MODULO(60), .DIGITS(2), .PRESCALE(4)) u_sec (
      .clk(clk), .reset(reset), .enable(sec_en), .clear(1'b0), .dir(1'b1),
      .load(1'b0), .load_val(6'd0), .count(sec_count), .bcd(sec_bcd), .seg(sec_seg), .tc(sec_tc)
   );

   stopwatch_stage #(.MODULO(60), .DIGITS(2), .PRESCALE(1)) u_min (
      .clk(clk), .reset(reset), .enable(sec_tc), .clear(1'b0), .dir(1'b1),
      .load(1'b0), .load_val(6'd0), .count(min_count), .bcd(min_bcd), .seg(min_seg), .tc(min_tc)
   );

   typedef struct {
      logic       clr;
      logic       ld;
      logic       en;
      logic       dr;
      logic [5:0] ldv;
      int         cyc;
      logic [5:0] e_cnt;
      logic [7:0] e_bcd;
   } vec_t;

   vec_t vecs[15];

   function automatic logic [6:0] seg_ref(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0000100;
         default: return 7'b1111110;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      //            clr   ld    en    dir   ldv    cyc  cnt    bcd
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  4,  6'd1,  8'h01};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  8,  6'd3,  8'h03};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd37, 1,  6'd37, 8'h37};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd63, 1,  6'd59, 8'h59};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  4,  6'd0,  8'h00};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  4,  6'd59, 8'h59};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  4,  6'd58, 8'h58};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd20, 1,  6'd20, 8'h20};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd20, 1,  6'd0,  8'h00};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd9,  1,  6'd9,  8'h09};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  4,  6'd10, 8'h10};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  4,  6'd9,  8'h09};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  10, 6'd9,  8'h09};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd0,  1,  6'd0,  8'h00};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd60, 1,  6'd59, 8'h59};

      // Reset state, with enable/dir set so a leaky carry would show
      enable = 1'b1;
      dir    = 1'b0;
      #12;
      chk("reset_count", count, 6'd0);
      chk("reset_bcd", bcd, 8'h00);
      chk("reset_seg", seg, {7'b0000001, 7'b0000001});
      chk("reset_tc", tc, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         clear    = vecs[i].clr;
         load     = vecs[i].ld;
         enable   = vecs[i].en;
         dir      = vecs[i].dr;
         load_val = vecs[i].ldv;
         edges(vecs[i].cyc);
         chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
         chk($sformatf("vec%0d_bcd", i), bcd, vecs[i].e_bcd);
         chk($sformatf("vec%0d_seg_lo", i), seg[6:0], seg_ref(vecs[i].e_bcd[3:0]));
         chk($sformatf("vec%0d_seg_hi", i), seg[13:7], seg_ref(vecs[i].e_bcd[7:4]));
      end
      chk("load37_seg_ones", seg_ref(4'd7), 7'b0001111);

      // Up wrap: exactly one carry sample at count 59, masked by clear
      clear = 1'b0; load = 1'b1; load_val = 6'd56; enable = 1'b1; dir = 1'b1;
      edges(1);
      load = 1'b0;
      edges(12);
      chk("upwrap_at59", count, 6'd59);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("upwrap_tc%0d", k), tc, (k == 3));
         if (k == 3) begin
            clear = 1'b1;
            #1;
            chk("tc_clear_mask", tc, 1'b0);
            clear = 1'b0;
            #1;
         end
         edges(1);
      end
      chk("upwrap_count", count, 6'd0);
      chk("upwrap_bcd", bcd, 8'h00);

      // Down wrap from zero
      dir = 1'b0;
      edges(3);
      chk("downwrap_tc", tc, 1'b1);
      edges(1);
      chk("downwrap_count", count, 6'd59);
      chk("downwrap_bcd", bcd, 8'h59);
      chk("downwrap_tc_after", tc, 1'b0);
      edges(4);
      chk("downwrap_next", count, 6'd58);

      // Async reset mid-prescale, then full prescale before first tick
      edges(2);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_count", count, 6'd0);
      chk("areset_bcd", bcd, 8'h00);
      chk("areset_seg", seg, {7'b0000001, 7'b0000001});
      chk("areset_tc", tc, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      dir = 1'b1;
      edges(3);
      chk("post_reset_3", count, 6'd0);
      edges(1);
      chk("post_reset_4", count, 6'd1);

      // Pause holds prescaler: resume needs only the remaining cycles
      edges(2);
      enable = 1'b0;
      edges(10);
      chk("pause_count", count, 6'd1);
      enable = 1'b1;
      edges(1);
      chk("resume_1", count, 6'd1);
      edges(1);
      chk("resume_2", count, 6'd2);

      // Direction change mid-prescale keeps the prescaler phase
      edges(2);
      dir = 1'b0;
      edges(1);
      chk("dirchg_1", count, 6'd2);
      edges(1);
      chk("dirchg_2", count, 6'd1);

      // Seconds -> minutes cascade
      sec_en = 1'b1;
      edges(239);
      chk("casc_sec59", sec_count, 6'd59);
      chk("casc_min0", min_count, 6'd0);
      chk("casc_sec_tc", sec_tc, 1'b1);
      edges(1);
      chk("casc_sec0", sec_count, 6'd0);
      chk("casc_sec_bcd", sec_bcd, 8'h00);
      chk("casc_sec_seg", sec_seg, {7'b0000001, 7'b0000001});
      chk("casc_min1", min_count, 6'd1);
      chk("casc_min_bcd", min_bcd, 8'h01);
      chk("casc_min_seg", min_seg, {7'b0000001, 7'b1001111});
      chk("casc_sec_tc_off", sec_tc, 1'b0);
      chk("casc_min_tc", min_tc, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
